// File: rtl/anita_hold_buffer_scheduler.sv
// anita_hold_buffer_scheduler
//
// Purpose:
//   Schedules the SURF hold buffers in the TURF trigger path. A one-cycle
//   trigger from any source (RF, PPS1, PPS2, soft) claims the next free hold
//   buffer in round-robin order. The block raises that buffer's HOLD line,
//   waits a settle time and then issues a one-cycle digitize command. After
//   the command it enforces a holdoff before the next trigger is taken.
//   The readout side releases buffers with clear pulses. Deadtime and
//   dropped-trigger counts are reported.
//
// Ports:
//   clk250_i          in   system trigger clock (only clock)
//   rst_n_i           in   asynchronous active-low reset
//   trig_i[3:0]       in   trigger pulses: [0] RF, [1] PPS1, [2] PPS2, [3] soft
//   clear_i           in   one-cycle release of buffer clear_buffer_i
//   clear_buffer_i    in   index of the buffer to release
//   HOLD_o            out  per-buffer hold lines (registered)
//   digitize_o        out  one-cycle digitize command
//   digitize_buffer_o out  buffer being digitized, held until next digitize
//   digitize_source_o out  trigger sources captured at acceptance
//   buffer_status_o   out  buffer occupancy (same as HOLD_o)
//   dead_o            out  a trigger cannot be accepted this cycle
//   dropped_o         out  saturating count of cycles with triggers while dead
//   clear_err_o       out  sticky flag: a clear targeted a buffer not held

module anita_hold_buffer_scheduler #(
  parameter int NUM_BUF     = 4,
  parameter int HOLD_SETTLE = 8,
  parameter int HOLDOFF     = 16
) (
  input  logic               clk250_i,
  input  logic               rst_n_i,
  input  logic [3:0]         trig_i,
  input  logic               clear_i,
  input  logic [1:0]         clear_buffer_i,
  output logic [NUM_BUF-1:0] HOLD_o,
  output logic               digitize_o,
  output logic [1:0]         digitize_buffer_o,
  output logic [3:0]         digitize_source_o,
  output logic [NUM_BUF-1:0] buffer_status_o,
  output logic               dead_o,
  output logic [15:0]        dropped_o,
  output logic               clear_err_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_DIGI,
    ST_HOLDOFF
  } state_t;

  state_t               state, state_next;
  logic [7:0]           cnt, cnt_next;
  logic [1:0]           last_buf;
  logic [NUM_BUF-1:0]   hold, hold_next;
  logic [1:0]           dig_buf;
  logic [3:0]           dig_src;
  logic [15:0]          dropped;
  logic                 clear_err;

  logic                 accept;
  logic                 alloc_found;
  logic [1:0]           alloc_idx;
  logic [1:0]           cand;
  logic                 clear_valid;
  logic                 dead;

  // Deadtime comes only from registered state, so it is glitch-free relative
  // to the clock and is low out of reset.
  assign dead = (state != ST_IDLE) || (&hold);

  // Round-robin search for the first free buffer starting after the last one
  // allocated. The search uses the hold mask before any same-cycle clear, so
  // a buffer released this cycle only becomes allocatable on the next one.
  always_comb begin
    alloc_found = 1'b0;
    alloc_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NUM_BUF; i++) begin
      cand = 2'((int'(last_buf) + 1 + i) % NUM_BUF);
      if (!alloc_found && !hold[cand]) begin
        alloc_found = 1'b1;
        alloc_idx   = cand;
      end
    end
  end

  // A clear only acts on a buffer that exists and is currently held;
  // anything else is reported through the sticky error flag instead.
  assign clear_valid = clear_i && (int'(clear_buffer_i) < NUM_BUF) && hold[clear_buffer_i];

  // Sequence controller: accept in IDLE, count down the settle time, pulse
  // digitize for one cycle, then count down the holdoff before re-arming.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    case (state)
      ST_IDLE: begin
        if ((trig_i != 4'd0) && alloc_found) begin
          accept     = 1'b1;
          cnt_next   = 8'(HOLD_SETTLE - 1);
          state_next = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt == 8'd0) begin
          state_next = ST_DIGI;
        end else begin
          cnt_next = cnt - 8'd1;
        end
      end
      ST_DIGI: begin
        if (HOLDOFF == 0) begin
          state_next = ST_IDLE;
        end else begin
          cnt_next   = 8'(HOLDOFF - 1);
          state_next = ST_HOLDOFF;
        end
      end
      ST_HOLDOFF: begin
        if (cnt == 8'd0) begin
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt - 8'd1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Hold mask update: a release and an allocation can land together and
  // never collide, since the allocated buffer was free beforehand.
  always_comb begin
    hold_next = hold;
    if (clear_valid) begin
      hold_next[clear_buffer_i] = 1'b0;
    end
    if (accept) begin
      hold_next[alloc_idx] = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk250_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Buffer bookkeeping, captured trigger info and error/drop accounting.
  // last_buf resets to the top index so the first allocation lands on 0.
  always_ff @(posedge clk250_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hold      <= '0;
      last_buf  <= 2'(NUM_BUF - 1);
      dig_buf   <= '0;
      dig_src   <= '0;
      dropped   <= '0;
      clear_err <= 1'b0;
    end else begin
      hold <= hold_next;
      if (accept) begin
        last_buf <= alloc_idx;
        dig_buf  <= alloc_idx;
        dig_src  <= trig_i;
      end
      if ((trig_i != 4'd0) && dead && (dropped != 16'hFFFF)) begin
        dropped <= dropped + 16'd1;
      end
      if (clear_i && !clear_valid) begin
        clear_err <= 1'b1;
      end
    end
  end

  assign HOLD_o            = hold;
  assign buffer_status_o   = hold;
  assign digitize_o        = (state == ST_DIGI);
  assign digitize_buffer_o = dig_buf;
  assign digitize_source_o = dig_src;
  assign dead_o            = dead;
  assign dropped_o         = dropped;
  assign clear_err_o       = clear_err;

endmodule

// File: tb/tb_anita_hold_buffer_scheduler.sv
// tb_anita_hold_buffer_scheduler
//
// Purpose:
//   Directed bench for anita_hold_buffer_scheduler with default parameters
//   (4 buffers, settle 8, holdoff 16). Inputs change 1 time unit after the
//   rising edge and outputs are sampled at the same point.
//
// Ports: none (top-level bench).

module tb_anita_hold_buffer_scheduler;

  logic        clk250;
  logic        rst_n;
  logic [3:0]  trig;
  logic        clear;
  logic [1:0]  clear_buffer;
  logic [3:0]  hold;
  logic        digitize;
  logic [1:0]  digitize_buffer;
  logic [3:0]  digitize_source;
  logic [3:0]  buffer_status;
  logic        dead;
  logic [15:0] dropped;
  logic        clear_err;

  int vectors = 0;
  int miscompares = 0;

  anita_hold_buffer_scheduler #(
    .NUM_BUF    (4),
    .HOLD_SETTLE(8),
    .HOLDOFF    (16)
  ) dut (
    .clk250_i         (clk250),
    .rst_n_i          (rst_n),
    .trig_i           (trig),
    .clear_i          (clear),
    .clear_buffer_i   (clear_buffer),
    .HOLD_o           (hold),
    .digitize_o       (digitize),
    .digitize_buffer_o(digitize_buffer),
    .digitize_source_o(digitize_source),
    .buffer_status_o  (buffer_status),
    .dead_o           (dead),
    .dropped_o        (dropped),
    .clear_err_o      (clear_err)
  );

  // 10-unit clock period.
  initial begin
    clk250 = 1'b0;
    forever #5 clk250 = ~clk250;
  end

  // Single comparison point: counts every vector and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk250);
    #1;
  endtask

  // Drive a trigger/clear pattern for exactly one sampling edge.
  task automatic applyStimulus(input logic [3:0] t, input logic c, input logic [1:0] cb);
    trig         = t;
    clear        = c;
    clear_buffer = cb;
    step();
    trig         = 4'd0;
    clear        = 1'b0;
    clear_buffer = 2'd0;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
  endtask

  // Accept a trigger, confirm latency, buffer and source, then idle long
  // enough for the holdoff to expire.
  task automatic runTrigger(input string tag, input logic [3:0] t, input logic [1:0] exp_buf);
    int n;
    applyStimulus(t, 1'b0, 2'd0);
    n = 0;
    while (!digitize && n < 40) begin
      step();
      n++;
    end
    checkOutput({tag, "_lat"}, n, 8);
    checkOutput({tag, "_buf"}, digitize_buffer, exp_buf);
    checkOutput({tag, "_src"}, digitize_source, t);
    repeat (20) step();
  endtask

  initial begin
    int n;
    int pulses;
    trig         = 4'd0;
    clear        = 1'b0;
    clear_buffer = 2'd0;
    rst_n        = 1'b0;

    // Reset state.
    repeat (2) step();
    checkOutput("rst_hold", hold, 4'b0000);
    checkOutput("rst_status", buffer_status, 4'b0000);
    checkOutput("rst_digi", digitize, 1'b0);
    checkOutput("rst_dbuf", digitize_buffer, 2'd0);
    checkOutput("rst_dsrc", digitize_source, 4'd0);
    checkOutput("rst_dead", dead, 1'b0);
    checkOutput("rst_drop", dropped, 16'd0);
    checkOutput("rst_err", clear_err, 1'b0);
    rst_n = 1'b1;
    step();

    // First trigger: buffer 0, digitize after T+8, dead low after T+25.
    applyStimulus(4'b0001, 1'b0, 2'd0);
    checkOutput("t1_hold", hold, 4'b0001);
    checkOutput("t1_dead", dead, 1'b1);
    n = 0;
    while (!digitize && n < 40) begin
      step();
      n++;
    end
    checkOutput("t1_digi_lat", n, 8);
    checkOutput("t1_dbuf", digitize_buffer, 2'd0);
    checkOutput("t1_dsrc", digitize_source, 4'b0001);
    step();
    n++;
    checkOutput("t1_digi_width", digitize, 1'b0);
    while (dead && n < 60) begin
      step();
      n++;
    end
    checkOutput("t1_dead_len", n, 25);

    // Round-robin from reset until full.
    doReset();
    runTrigger("rr0", 4'b0001, 2'd0);
    runTrigger("rr1", 4'b0010, 2'd1);
    runTrigger("rr2", 4'b0100, 2'd2);
    runTrigger("rr3", 4'b1000, 2'd3);
    checkOutput("full_hold", hold, 4'b1111);
    checkOutput("full_dead", dead, 1'b1);
    applyStimulus(4'b0001, 1'b0, 2'd0);
    checkOutput("full_drop", dropped, 16'd1);
    pulses = 0;
    repeat (20) begin
      step();
      if (digitize) pulses++;
    end
    checkOutput("full_nodigi", pulses, 0);
    checkOutput("full_dead2", dead, 1'b1);

    // Clear buffer 2 and reallocate it (search starts at 0).
    applyStimulus(4'b0000, 1'b1, 2'd2);
    checkOutput("clr_hold", hold, 4'b1011);
    checkOutput("clr_dead", dead, 1'b0);
    runTrigger("realloc", 4'b0100, 2'd2);
    checkOutput("realloc_hold", hold, 4'b1111);

    // Clear of buffer 1 coincident with a trigger while full.
    applyStimulus(4'b0001, 1'b1, 2'd1);
    checkOutput("same_hold", hold, 4'b1101);
    checkOutput("same_drop", dropped, 16'd2);
    checkOutput("same_err", clear_err, 1'b0);

    // Clearing a free buffer sets the sticky error.
    applyStimulus(4'b0000, 1'b1, 2'd1);
    checkOutput("err_set", clear_err, 1'b1);
    checkOutput("err_hold", hold, 4'b1101);
    repeat (5) step();
    checkOutput("err_sticky", clear_err, 1'b1);

    // Coincident sources take one buffer (1, after last=2 and 3,0 held).
    applyStimulus(4'b1010, 1'b0, 2'd0);
    checkOutput("coin_hold", hold, 4'b1111);
    step();
    applyStimulus(4'b0001, 1'b0, 2'd0);
    checkOutput("settle_drop", dropped, 16'd3);
    n = 0;
    while (!digitize && n < 40) begin
      step();
      n++;
    end
    checkOutput("coin_digi", digitize, 1'b1);
    checkOutput("coin_dbuf", digitize_buffer, 2'd1);
    checkOutput("coin_dsrc", digitize_source, 4'b1010);
    step();
    applyStimulus(4'b1000, 1'b0, 2'd0);
    checkOutput("holdoff_drop", dropped, 16'd4);
    checkOutput("holdoff_dsrc", digitize_source, 4'b1010);
    repeat (25) step();
    checkOutput("coin_dead", dead, 1'b1);

    // Saturation of the drop counter while full.
    trig = 4'b0001;
    repeat (65535 - 4 - 1) step();
    checkOutput("sat_pre", dropped, 16'hFFFE);
    step();
    checkOutput("sat_hit", dropped, 16'hFFFF);
    repeat (3) step();
    checkOutput("sat_hold", dropped, 16'hFFFF);
    trig = 4'd0;

    // Reset asserted during SETTLE aborts the sequence.
    doReset();
    applyStimulus(4'b0001, 1'b0, 2'd0);
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_hold", hold, 4'b0000);
    checkOutput("mid_dead", dead, 1'b0);
    checkOutput("mid_drop", dropped, 16'd0);
    checkOutput("mid_err", clear_err, 1'b0);
    checkOutput("mid_dbuf", digitize_buffer, 2'd0);
    checkOutput("mid_dsrc", digitize_source, 4'd0);
    checkOutput("mid_digi", digitize, 1'b0);
    step();
    rst_n = 1'b1;
    pulses = 0;
    repeat (20) begin
      step();
      if (digitize) pulses++;
    end
    checkOutput("mid_nodigi", pulses, 0);
    checkOutput("mid_hold2", hold, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
